// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : imem_responder
// Description : Instruction memory with fixed-latency fetch and a 2-entry
//               in-order response FIFO; flush discards in-flight fetches.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic        rsp_err,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int          AW    = $clog2(DEPTH);
  localparam int          CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [31:0] c_nop = 32'h0000_0013;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_addr;
  logic [31:0]     r_mem [DEPTH];
  logic [31:0]     r_fifo_instr [2];
  logic [1:0]      r_fifo_err;
  logic            r_rd_ptr;
  logic            r_wr_ptr;
  logic [1:0]      r_count;

  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_wr_in_range;
  logic            w_rd_bad;
  logic [31:0]     w_push_instr;
  logic            w_unused;

  // Byte-lane bits of the load address carry no meaning for word writes.
  assign w_unused      = ^wr_addr[1:0];

  assign w_wr_in_range = ({2'b00, wr_addr[31:2]} < 32'(DEPTH));
  assign w_rd_bad      = (r_addr[1:0] != 2'b00) ||
                         !({2'b00, r_addr[31:2]} < 32'(DEPTH));
  assign w_push_instr  = w_rd_bad ? c_nop : r_mem[r_addr[AW+1:2]];

  assign req_ready = (r_state == IDLE) && (r_count < 2'd2) && !flush;
  assign w_accept  = req_valid && req_ready;
  assign w_push    = (r_state == WAIT) && (r_cnt == '0) && !flush;
  assign rsp_valid = (r_count != 2'd0);
  assign w_pop     = rsp_valid && rsp_ready && !flush;
  assign rsp_instr = rsp_valid ? r_fifo_instr[r_rd_ptr] : 32'h0;
  assign rsp_err   = rsp_valid ? r_fifo_err[r_rd_ptr] : 1'b0;

  // Memory is deliberately outside reset so contents survive a core reset.
  always_ff @(posedge clk) begin
    if (wr_en && w_wr_in_range) begin
      r_mem[wr_addr[AW+1:2]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= 32'h0;
    end else if (flush) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr  <= req_addr;
            r_cnt   <= CW'(LATENCY - 1);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fifo_instr[0] <= 32'h0;
      r_fifo_instr[1] <= 32'h0;
      r_fifo_err      <= 2'b00;
      r_rd_ptr        <= 1'b0;
      r_wr_ptr        <= 1'b0;
      r_count         <= 2'd0;
    end else if (flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_instr[r_wr_ptr] <= w_push_instr;
        r_fifo_err[r_wr_ptr]   <= w_rd_bad;
        r_wr_ptr               <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_responder
// Description : Directed, table-driven self-checking bench for imem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic        flush = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_instr;
  logic        rsp_err;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = 32'h0;
  logic [31:0] wr_data = 32'h0;

  int total = 0;
  int bad   = 0;

  imem_responder #(.DEPTH(256), .LATENCY(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_err   (rsp_err),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic mem_write(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Holds req_valid until the request is taken; returns one step after accept.
  task automatic issue(input string name, input logic [31:0] a);
    int n = 0;
    req_valid = 1'b1; req_addr = a;
    while (!req_ready && n < 20) begin tick(); n++; end
    check({name, "_accept"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic fetch_check(input string name, input logic [31:0] a,
                             input logic [31:0] exp_i, input logic exp_e);
    int lat = 0;
    rsp_ready = 1'b1;
    issue(name, a);
    while (!rsp_valid && lat < 20) begin tick(); lat++; end
    check({name, "_latency"}, 32'(lat), 32'd2);
    check({name, "_instr"}, rsp_instr, exp_i);
    check({name, "_err"}, 32'(rsp_err), 32'(exp_e));
    tick();
  endtask

  logic [31:0] got_q [$];
  logic [31:0] saddr [3];
  logic [31:0] sexp  [3];
  int          idx;
  logic        acc;
  logic        seen;

  initial begin
    vecs[0] = '{"w0",        32'h0,   32'h0050_0093, 1'b0};
    vecs[1] = '{"w1",        32'h4,   32'h00A0_0113, 1'b0};
    vecs[2] = '{"w2_lowbits",32'h8,   32'h1111_1111, 1'b0};
    vecs[3] = '{"top_word",  32'h3FC, 32'hCAFE_F00D, 1'b0};
    vecs[4] = '{"misalign6", 32'h6,   NOP,           1'b1};
    vecs[5] = '{"oor_400",   32'h400, NOP,           1'b1};
    vecs[6] = '{"misalign1", 32'h1,   NOP,           1'b1};
    vecs[7] = '{"w0_no_alias", 32'h0, 32'h0050_0093, 1'b0};

    // Reset state
    #2;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_instr", rsp_instr, 32'h0);
    check("rst_err", 32'(rsp_err), 32'd0);
    tick(); tick();
    reset = 1'b1;
    #1;
    check("ready_after_rst", 32'(req_ready), 32'd1);
    tick();

    mem_write(32'h0,   32'h0050_0093);
    mem_write(32'h4,   32'h00A0_0113);
    mem_write(32'hB,   32'h1111_1111);
    mem_write(32'hC,   32'h3333_3333);
    mem_write(32'h3FC, 32'hCAFE_F00D);
    mem_write(32'h400, 32'hDEAD_BEEF);

    for (int i = 0; i < 8; i++) begin
      fetch_check(vecs[i].name, vecs[i].addr, vecs[i].instr, vecs[i].err);
    end
    check("idle_instr_zero", rsp_instr, 32'h0);

    // Read-before-write: write lands on the same edge as the push
    issue("rbw", 32'hC);
    tick();
    wr_en = 1'b1; wr_addr = 32'hC; wr_data = 32'h4444_4444;
    tick();
    wr_en = 1'b0;
    check("rbw_valid", 32'(rsp_valid), 32'd1);
    check("rbw_old", rsp_instr, 32'h3333_3333);
    tick();
    fetch_check("rbw_new", 32'hC, 32'h4444_4444, 1'b0);

    // Backpressure: two buffered entries block further requests
    rsp_ready = 1'b0;
    issue("bp0", 32'h0);
    issue("bp1", 32'h4);
    tick(); tick();
    check("bp_valid", 32'(rsp_valid), 32'd1);
    check("bp_ready_low", 32'(req_ready), 32'd0);
    tick();
    check("bp_ready_still_low", 32'(req_ready), 32'd0);
    check("bp_head0", rsp_instr, 32'h0050_0093);
    rsp_ready = 1'b1;
    tick();
    check("bp_head1", rsp_instr, 32'h00A0_0113);
    tick();
    check("bp_empty", 32'(rsp_valid), 32'd0);

    // Flush right after accept: nothing may come out
    issue("fl", 32'h4);
    flush = 1'b1;
    #1;
    check("fl_ready_gated", 32'(req_ready), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("fl_ready_after", 32'(req_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) seen = 1'b1;
      tick();
    end
    check("fl_no_rsp", 32'(seen), 32'd0);

    // Flush discards a buffered entry
    rsp_ready = 1'b0;
    issue("flb", 32'h0);
    tick(); tick();
    check("flb_buffered", 32'(rsp_valid), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flb_emptied", 32'(rsp_valid), 32'd0);

    // Asynchronous reset with one entry buffered
    issue("ar", 32'h4);
    tick(); tick();
    check("ar_buffered", 32'(rsp_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_valid_now", 32'(rsp_valid), 32'd0);
    check("ar_instr_now", rsp_instr, 32'h0);
    #3;
    reset = 1'b1;
    tick();
    fetch_check("ar_mem_kept", 32'h0, 32'h0050_0093, 1'b0);

    // Streaming three requests with the consumer always ready
    saddr[0] = 32'h0; saddr[1] = 32'h4; saddr[2] = 32'h8;
    sexp[0] = 32'h0050_0093; sexp[1] = 32'h00A0_0113; sexp[2] = 32'h1111_1111;
    rsp_ready = 1'b1;
    idx = 0;
    req_valid = 1'b1; req_addr = saddr[0];
    for (int c = 0; c < 40; c++) begin
      acc = req_valid && req_ready;
      if (rsp_valid) got_q.push_back(rsp_instr);
      tick();
      if (acc) idx++;
      req_valid = (idx < 3);
      req_addr  = (idx < 3) ? saddr[idx] : 32'h0;
    end
    check("stream_count", 32'(got_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stream_%0d", i), (i < got_q.size()) ? got_q[i] : 32'hX, sexp[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
